// File: rtl/binary_down_timer.sv
// Loadable N-bit down timer with start/pause/stop control, optional auto-reload,
// and a registered single-cycle done pulse on expiry.
module binary_down_timer #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_valid,
  input  logic [N-1:0] load_value,
  output logic         load_ready,
  input  logic         start,
  input  logic         pause,
  input  logic         stop,
  input  logic         auto_reload,
  output logic [N-1:0] count,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {StIdle, StLoaded, StRun, StPaused} state_e;

  localparam logic [N-1:0] CountOne = N'(1);

  state_e       state_q, state_d;
  logic [N-1:0] count_q, count_d;
  logic [N-1:0] reload_q, reload_d;
  logic         done_q, done_d;
  logic         load_accept;

  always_comb begin
    load_ready  = (state_q == StIdle) || (state_q == StLoaded);
    // A stop in LOADED wins over a simultaneous load; stop is a no-op in IDLE.
    load_accept = load_valid && load_ready && !((state_q == StLoaded) && stop);
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;

    if (load_accept) begin
      count_d  = load_value;
      reload_d = load_value;
      state_d  = StLoaded;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StIdle;
        end
        StLoaded: begin
          if (stop) begin
            state_d = StIdle;
          end else if (start) begin
            if (count_q != '0) begin
              state_d = StRun;
            end else begin
              done_d  = 1'b1;
              state_d = StIdle;
            end
          end
        end
        StRun: begin
          if (stop) begin
            state_d = StIdle;
          end else if (pause) begin
            state_d = StPaused;
          end else if (count_q <= CountOne) begin
            // Expiry edge; the <= guard also keeps a zero count from wrapping.
            done_d = 1'b1;
            if (auto_reload) begin
              count_d = reload_q;
            end else begin
              count_d = '0;
              state_d = StIdle;
            end
          end else begin
            count_d = count_q - CountOne;
          end
        end
        StPaused: begin
          if (stop) begin
            state_d = StIdle;
          end else if (!pause) begin
            state_d = StRun;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    count = count_q;
    busy  = (state_q == StRun) || (state_q == StPaused);
    done  = done_q;
  end

endmodule

// File: tb/tb_binary_down_timer.sv
// Self-checking bench for binary_down_timer: directed vector table, hand-written
// multi-cycle sequences, and random stimulus against a behavioural model.
module tb_binary_down_timer;

  localparam int unsigned N = 8;

  logic         clk;
  logic         reset;
  logic         load_valid;
  logic [N-1:0] load_value;
  logic         load_ready;
  logic         start;
  logic         pause;
  logic         stop;
  logic         auto_reload;
  logic [N-1:0] count;
  logic         busy;
  logic         done;

  int errors = 0;
  int checks = 0;

  binary_down_timer #(.N(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .load_valid  (load_valid),
    .load_value  (load_value),
    .load_ready  (load_ready),
    .start       (start),
    .pause       (pause),
    .stop        (stop),
    .auto_reload (auto_reload),
    .count       (count),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: flags describe what the timer is doing, count is a plain int.
  int m_count  = 0;
  int m_reload = 0;
  bit m_armed  = 0;
  bit m_run    = 0;
  bit m_paused = 0;
  bit m_done   = 0;

  task automatic model_step(input bit rst, input bit lv, input int val, input bit st,
                            input bit pa, input bit sp, input bit ar);
    m_done = 0;
    if (rst) begin
      m_count = 0; m_reload = 0; m_armed = 0; m_run = 0; m_paused = 0;
    end else if (!m_run && !m_paused) begin
      if (m_armed && sp) begin
        m_armed = 0;
      end else if (lv) begin
        m_count = val; m_reload = val; m_armed = 1;
      end else if (m_armed && st) begin
        m_armed = 0;
        if (m_count > 0) m_run = 1;
        else m_done = 1;
      end
    end else if (sp) begin
      m_run = 0; m_paused = 0;
    end else if (m_paused) begin
      if (!pa) begin
        m_paused = 0; m_run = 1;
      end
    end else if (pa) begin
      m_run = 0; m_paused = 1;
    end else if (m_count == 1) begin
      m_done = 1;
      if (ar) m_count = m_reload;
      else begin
        m_count = 0; m_run = 0;
      end
    end else begin
      m_count = m_count - 1;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model, and sample just after the edge.
  task automatic cyc(input bit rst, input bit lv, input int val, input bit st,
                     input bit pa, input bit sp, input bit ar, input bit cmp);
    reset = rst; load_valid = lv; load_value = N'(val); start = st;
    pause = pa; stop = sp; auto_reload = ar;
    @(posedge clk);
    model_step(rst, lv, val, st, pa, sp, ar);
    #1;
    if (cmp) begin
      chk("model_count", int'(count), m_count);
      chk("model_busy", int'(busy), int'(m_run || m_paused));
      chk("model_done", int'(done), int'(m_done));
      chk("model_ready", int'(load_ready), int'(!(m_run || m_paused)));
    end
  endtask

  typedef struct {
    bit rst; bit lv; int val; bit st; bit pa; bit sp; bit ar;
    int e_count; bit e_busy; bit e_done; bit e_ready;
  } vec_t;

  vec_t vecs[18];

  initial begin
    int done_cnt;
    int busy_cnt;
    int four_cnt;
    bit seen_done;

    reset = 1; load_valid = 0; load_value = '0; start = 0;
    pause = 0; stop = 0; auto_reload = 0;

    //           rst lv val st pa sp ar  cnt busy done ready
    vecs[0]  = '{1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1};  // reset state
    vecs[1]  = '{0, 1, 5, 0, 0, 0, 0,  5, 0, 0, 1};  // load 5
    vecs[2]  = '{0, 0, 0, 1, 0, 0, 0,  5, 1, 0, 0};  // start
    vecs[3]  = '{0, 0, 0, 0, 0, 0, 0,  4, 1, 0, 0};
    vecs[4]  = '{0, 0, 0, 0, 0, 0, 0,  3, 1, 0, 0};
    vecs[5]  = '{0, 0, 0, 0, 0, 0, 0,  2, 1, 0, 0};
    vecs[6]  = '{0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0};
    vecs[7]  = '{0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1};  // expiry, no reload
    vecs[8]  = '{0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1};  // done is one cycle
    vecs[9]  = '{0, 1, 7, 0, 0, 0, 0,  7, 0, 0, 1};
    vecs[10] = '{0, 1, 9, 1, 0, 0, 0,  9, 0, 0, 1};  // load beats start
    vecs[11] = '{0, 0, 0, 1, 0, 0, 0,  9, 1, 0, 0};
    vecs[12] = '{0, 1, 2, 0, 0, 0, 0,  8, 1, 0, 0};  // load ignored in RUN
    vecs[13] = '{0, 0, 0, 0, 1, 1, 0,  8, 0, 0, 1};  // stop+pause -> IDLE, frozen
    vecs[14] = '{0, 0, 0, 1, 0, 0, 0,  8, 0, 0, 1};  // start ignored in IDLE
    vecs[15] = '{0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 1};  // load 0
    vecs[16] = '{0, 0, 0, 1, 0, 0, 0,  0, 0, 1, 1};  // zero start -> done
    vecs[17] = '{0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1};

    foreach (vecs[i]) begin
      cyc(vecs[i].rst, vecs[i].lv, vecs[i].val, vecs[i].st, vecs[i].pa, vecs[i].sp,
          vecs[i].ar, 1'b0);
      chk($sformatf("vec%0d_count", i), int'(count), vecs[i].e_count);
      chk($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].e_busy));
      chk($sformatf("vec%0d_done", i), int'(done), int'(vecs[i].e_done));
      chk($sformatf("vec%0d_ready", i), int'(load_ready), int'(vecs[i].e_ready));
    end

    // Auto-reload: 3,2,1,3,2,1... with done on every reload.
    cyc(1, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 1, 3, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 0, 0, 1, 1);
    done_cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      cyc(0, 0, 0, 0, 0, 0, 1, 1);
      chk("reload_count", int'(count), 3 - (k % 3));
      chk("reload_done", int'(done), int'(k % 3 == 0));
      chk("reload_busy", int'(busy), 1);
      if (done) done_cnt++;
    end
    chk("reload_done_total", done_cnt, 4);

    // Pause at count 4 for four cycles, then run to expiry.
    cyc(1, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 1, 6, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 0, 0, 1);
    busy_cnt = 1;
    four_cnt = 0;
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    busy_cnt++;
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    busy_cnt++;
    four_cnt++;
    chk("pause_at4", int'(count), 4);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 0, 0, 1, 0, 0, 1);
      if (busy) busy_cnt++;
      if (count == 4) four_cnt++;
    end
    seen_done = 0;
    for (int k = 0; k < 40 && !seen_done; k++) begin
      cyc(0, 0, 0, 0, 0, 0, 0, 1);
      if (busy) busy_cnt++;
      if (count == 4) four_cnt++;
      if (done) seen_done = 1;
    end
    chk("pause_done_seen", int'(seen_done), 1);
    chk("pause_run_len", busy_cnt, 6 + 4 + 1);
    chk("pause_hold4", four_cnt, 1 + 4 + 1);

    // Stop at count 2: frozen, no done.
    cyc(0, 1, 4, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1, 0, 1);
    chk("stop_count", int'(count), 2);
    chk("stop_busy", int'(busy), 0);
    chk("stop_done", int'(done), 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    chk("stop_no_late_done", int'(done), 0);

    // Reset at count 1 with auto_reload: no done, back to idle.
    cyc(0, 1, 2, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 1, 1);
    chk("rst_pre_count", int'(count), 1);
    cyc(1, 0, 0, 0, 0, 0, 1, 1);
    chk("rst_count", int'(count), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ready", int'(load_ready), 1);
    cyc(0, 0, 0, 0, 0, 0, 1, 1);
    chk("rst_done_after", int'(done), 0);

    // Random stimulus against the model.
    for (int k = 0; k < 3000; k++) begin
      cyc(($urandom % 64) == 0, ($urandom % 4) == 0, int'($urandom_range(0, 12)),
          ($urandom % 3) == 0, ($urandom % 6) == 0, ($urandom % 20) == 0,
          ($urandom % 2) == 0, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
